tick_rate_controller: RTL and testbench



---
 rtl/tick_rate_controller_pkg.sv | 53 +++++
 rtl/tick_rate_controller_rate_down_counter.sv | 27 ++
 rtl/tick_rate_controller.sv | 113 +++++++++++
 tb/tb_tick_rate_controller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_controller_pkg.sv
// Shared frequency constants, level/select codes and helpers for the tick rate controller.
package tick_rate_controller_pkg;

    typedef logic [1:0] level_t;
    typedef logic [1:0] select_t;

    localparam level_t LEVEL_SLOW = 2'd0;
    localparam level_t LEVEL_MID  = 2'd1;
    localparam level_t LEVEL_FAST = 2'd2;
    localparam level_t LEVEL_TOP  = 2'd3;

    localparam select_t SEL_DIV1 = 2'b00;
    localparam select_t SEL_SLOW = 2'b01;
    localparam select_t SEL_MID  = 2'b10;
    localparam select_t SEL_FAST = 2'b11;

    localparam int unsigned DEF_DIV_SLOW = 5_000_000;
    localparam int unsigned DEF_DIV_MID  = 2_500_000;
    localparam int unsigned DEF_DIV_FAST = 1_250_000;
    localparam int unsigned DEF_DIV_TOP  = 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    function automatic select_t level_to_select(input level_t lvl);
        select_t sel;
        case (lvl)
            LEVEL_SLOW: sel = SEL_SLOW;
            LEVEL_MID:  sel = SEL_MID;
            LEVEL_FAST: sel = SEL_FAST;
            default:    sel = SEL_DIV1;
        endcase
        return sel;
    endfunction

    // The top level runs every cycle, so its divisor is fixed rather than parameterised.
    function automatic int unsigned level_to_div(input level_t lvl,
                                                 input int unsigned div_slow,
                                                 input int unsigned div_mid,
                                                 input int unsigned div_fast);
        int unsigned div;
        case (lvl)
            LEVEL_SLOW: div = div_slow;
            LEVEL_MID:  div = div_mid;
            LEVEL_FAST: div = div_fast;
            default:    div = DEF_DIV_TOP;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/tick_rate_controller_rate_down_counter.sv
// Loadable down-counter that sets the tick period; the controller decides when to load or hold.
module rate_down_counter #(
    parameter int unsigned          CNT_W     = 32,
    parameter logic [CNT_W-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (!hold) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/tick_rate_controller.sv
// Speed level, run/pause state and the single-cycle update tick that drives the plotting datapath.
module tick_rate_controller
    import tick_rate_controller_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DIV_SLOW    = DEF_DIV_SLOW,
    parameter int unsigned DIV_MID     = DEF_DIV_MID,
    parameter int unsigned DIV_FAST    = DEF_DIV_FAST,
    parameter int unsigned RESET_LEVEL = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       speed_up,
    input  logic       speed_down,
    input  logic       pause_toggle,
    input  logic       step_req,
    output logic       tick,
    output logic [1:0] select,
    output logic [1:0] level,
    output logic       paused
);

    localparam level_t           RST_LEVEL = level_t'(RESET_LEVEL);
    localparam logic [CNT_W-1:0] RST_COUNT =
        CNT_W'(level_to_div(RST_LEVEL, DIV_SLOW, DIV_MID, DIV_FAST));

    state_t           state_q, state_d;
    level_t           level_q, level_d;
    select_t          select_q;
    logic             tick_q, tick_d;
    logic             armed_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] load_val;
    logic             cnt_load, cnt_hold, expire;
    logic             speed_change, step_fire, active;

    rate_down_counter #(
        .CNT_W     (CNT_W),
        .RESET_VAL (RST_COUNT)
    ) u_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (load_val),
        .hold     (cnt_hold),
        .count    (count),
        .expire   (expire)
    );

    // A speed change outranks any tick or step that lands in the same cycle; armed_q
    // keeps the first cycle after reset release tick-free even at divisor 1.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        speed_change = 1'b0;
        cnt_load     = 1'b0;
        cnt_hold     = 1'b1;
        tick_d       = 1'b0;

        if (pause_toggle) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        if (speed_up && !speed_down && level_q != LEVEL_TOP) begin
            level_d      = level_q + 2'd1;
            speed_change = 1'b1;
        end else if (speed_down && !speed_up && level_q != LEVEL_SLOW) begin
            level_d      = level_q - 2'd1;
            speed_change = 1'b1;
        end

        active    = (state_d == ST_RUN);
        step_fire = (state_q == ST_PAUSED) && step_req && !pause_toggle && !speed_change;
        load_val  = CNT_W'(level_to_div(level_d, DIV_SLOW, DIV_MID, DIV_FAST));

        if (speed_change) begin
            cnt_load = 1'b1;
        end else if (step_fire) begin
            cnt_load = 1'b1;
            tick_d   = armed_q;
        end else if (active) begin
            cnt_hold = 1'b0;
            if (expire) begin
                cnt_load = 1'b1;
                tick_d   = armed_q;
            end else if (count == '0) begin
                cnt_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_RUN;
            level_q  <= RST_LEVEL;
            select_q <= level_to_select(RST_LEVEL);
            tick_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            select_q <= level_to_select(level_d);
            tick_q   <= tick_d;
            armed_q  <= 1'b1;
        end
    end

    assign tick   = tick_q;
    assign select = select_q;
    assign level  = level_q;
    assign paused = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller with small divisors (8/4/2) and hand-computed tick timing.
module tb_tick_rate_controller;

    logic       clk;
    logic       resetn;
    logic       speed_up, speed_down, pause_toggle, step_req;
    logic       tick, paused;
    logic [1:0] select, level;

    int checks    = 0;
    int errors    = 0;
    int tickCount = 0;

    typedef struct {
        logic       su, sd, pt, sr;
        logic       expTick;
        logic [1:0] expLevel;
        logic [1:0] expSel;
        logic       expPaused;
    } vec_t;

    vec_t vecs[$];

    tick_rate_controller #(
        .CNT_W       (32),
        .DIV_SLOW    (8),
        .DIV_MID     (4),
        .DIV_FAST    (2),
        .RESET_LEVEL (0)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .speed_up     (speed_up),
        .speed_down   (speed_down),
        .pause_toggle (pause_toggle),
        .step_req     (step_req),
        .tick         (tick),
        .select       (select),
        .level        (level),
        .paused       (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic applyStimulus(input logic su, input logic sd, input logic pt, input logic sr);
        @(negedge clk);
        speed_up     = su;
        speed_down   = sd;
        pause_toggle = pt;
        step_req     = sr;
        @(posedge clk);
        #1;
        speed_up     = 1'b0;
        speed_down   = 1'b0;
        pause_toggle = 1'b0;
        step_req     = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic expTick, input logic [1:0] expLevel,
                               input logic [1:0] expSel, input logic expPaused);
        checks++;
        if (tick === 1'b1) tickCount++;
        if (tick !== expTick || level !== expLevel || select !== expSel || paused !== expPaused) begin
            errors++;
            $display("[TB] FAIL %s: got tick=%b level=%0d select=%b paused=%b, expected tick=%b level=%0d select=%b paused=%b",
                     name, tick, level, select, paused, expTick, expLevel, expSel, expPaused);
        end
    endtask

    // Idle cycles with ticks expected at firstAt, firstAt+period, ...
    task automatic idleCheck(input string name, input int n, input int period, input int firstAt,
                             input logic [1:0] lvl, input logic [1:0] sel, input logic p);
        for (int k = 1; k <= n; k++) begin
            logic expT;
            expT = (k >= firstAt) && (((k - firstAt) % period) == 0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("%s[%0d]", name, k), expT, lvl, sel, p);
        end
    endtask

    task automatic stepCheck(input string name, input logic su, input logic sd, input logic pt,
                             input logic sr, input logic expT, input logic [1:0] lvl,
                             input logic [1:0] sel, input logic p);
        applyStimulus(su, sd, pt, sr);
        checkOutput(name, expT, lvl, sel, p);
    endtask

    function automatic vec_t mkVec(input logic su, input logic sd, input logic pt, input logic sr,
                                   input logic t, input logic [1:0] l, input logic [1:0] s,
                                   input logic p);
        vec_t v;
        v.su = su; v.sd = sd; v.pt = pt; v.sr = sr;
        v.expTick = t; v.expLevel = l; v.expSel = s; v.expPaused = p;
        return v;
    endfunction

    task automatic runTable(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].su, vecs[i].sd, vecs[i].pt, vecs[i].sr);
            checkOutput($sformatf("%s[%0d]", name, i), vecs[i].expTick, vecs[i].expLevel,
                        vecs[i].expSel, vecs[i].expPaused);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        speed_up     = 1'b0;
        speed_down   = 1'b0;
        pause_toggle = 1'b0;
        step_req     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 2'd0, 2'b01, 1'b0);
        #2 resetn = 1'b1;

        // Level 0: first tick 8 cycles after release, then every 8
        tickCount = 0;
        idleCheck("lvl0_period", 32, 8, 8, 2'd0, 2'b01, 1'b0);
        checks++;
        if (tickCount != 4) begin
            errors++;
            $display("[TB] FAIL tick_count_32: got %0d ticks, expected 4", tickCount);
        end

        // Speed up through all levels, then saturate
        stepCheck("up_to_1", 1, 0, 0, 0, 1'b0, 2'd1, 2'b10, 1'b0);
        idleCheck("lvl1_period", 19, 4, 4, 2'd1, 2'b10, 1'b0);
        stepCheck("up_to_2", 1, 0, 0, 0, 1'b0, 2'd2, 2'b11, 1'b0);
        idleCheck("lvl2_period", 19, 2, 2, 2'd2, 2'b11, 1'b0);
        stepCheck("up_to_3", 1, 0, 0, 0, 1'b0, 2'd3, 2'b00, 1'b0);
        idleCheck("lvl3_period", 19, 1, 1, 2'd3, 2'b00, 1'b0);
        stepCheck("up_saturated", 1, 0, 0, 0, 1'b1, 2'd3, 2'b00, 1'b0);
        idleCheck("lvl3_hold", 5, 1, 1, 2'd3, 2'b00, 1'b0);

        // Speed-down, tick suppression on change, simultaneous up/down, pause at count 5
        vecs.delete();
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'd1, 2'b10, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd1, 2'b10, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd1, 2'b10, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd1, 2'b10, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'd1, 2'b10, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 2'd0, 2'b01, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd0, 2'b01, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd0, 2'b01, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd0, 2'b01, 0));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 2'd0, 2'b01, 1));
        runTable("speed_tbl");

        // Paused holds count 5; resume ticks 4 cycles later
        idleCheck("paused_hold", 50, 1, 99, 2'd0, 2'b01, 1'b1);
        stepCheck("resume", 0, 0, 1, 0, 1'b0, 2'd0, 2'b01, 1'b0);
        idleCheck("resume_ticks", 12, 8, 4, 2'd0, 2'b01, 1'b0);

        // Single-step while paused
        stepCheck("pause2", 0, 0, 1, 0, 1'b0, 2'd0, 2'b01, 1'b1);
        idleCheck("pause2_idle", 3, 1, 99, 2'd0, 2'b01, 1'b1);
        stepCheck("step1", 0, 0, 0, 1, 1'b1, 2'd0, 2'b01, 1'b1);
        idleCheck("step_gap", 9, 1, 99, 2'd0, 2'b01, 1'b1);
        stepCheck("step2", 0, 0, 0, 1, 1'b1, 2'd0, 2'b01, 1'b1);
        idleCheck("step_after", 3, 1, 99, 2'd0, 2'b01, 1'b1);
        stepCheck("step_and_toggle", 0, 0, 1, 1, 1'b0, 2'd0, 2'b01, 1'b0);
        idleCheck("run_after_step", 8, 8, 7, 2'd0, 2'b01, 1'b0);
        stepCheck("step_in_run", 0, 0, 0, 1, 1'b0, 2'd0, 2'b01, 1'b0);
        idleCheck("run_after_ignored", 6, 8, 6, 2'd0, 2'b01, 1'b0);

        // Combined events: speed+pause, speed+step while paused
        vecs.delete();
        vecs.push_back(mkVec(1, 0, 1, 0, 0, 2'd1, 2'b10, 1));
        vecs.push_back(mkVec(1, 0, 0, 1, 0, 2'd2, 2'b11, 1));
        vecs.push_back(mkVec(0, 0, 0, 1, 1, 2'd2, 2'b11, 1));
        vecs.push_back(mkVec(0, 0, 1, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 2'd2, 2'b11, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 2'd2, 2'b11, 0));
        runTable("combo_tbl");

        // Asynchronous reset mid-operation while tick is high
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 2'd0, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("in_reset[%0d]", i), 1'b0, 2'd0, 2'b01, 1'b0);
        end
        #2 resetn = 1'b1;
        idleCheck("after_reset", 16, 8, 8, 2'd0, 2'b01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
